// File: rtl/fifo_sync_cfg_pkg.sv
// Shared configuration helpers for the parametrised synchronous FIFO.
// Holds the read-mode encodings, the level-width derivation and the legality check
// for the depth/threshold combination.
package fifo_cfg_pkg;

  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // Level must be able to represent 0..DEPTH inclusive.
  function automatic int calc_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Legal configurations: DEPTH >= 2 and 0 <= AE < AF <= DEPTH.
  function automatic bit cfg_legal(input int depth, input int ae, input int af);
    return (depth >= 2) && (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_sync_cfg_if.sv
// Handshake bundle between a FIFO user and fifo_sync_cfg.
// No latency of its own; pure wiring.
// Backpressure is conveyed through full/overflow toward the master.
interface fifo_sync_cfg_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  import fifo_cfg_pkg::*;

  localparam int LVL_W = calc_lvl_w(DEPTH);

  logic                     flush;
  logic                     wr_en;
  logic signed [DATA_W-1:0] data_in;
  logic                     rd_en;
  logic signed [DATA_W-1:0] data_out;
  logic                     rd_valid;
  logic                     wr_ack;
  logic                     overflow;
  logic                     underflow;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [LVL_W-1:0]         level;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
    input  full, empty, almost_full, almost_empty, level
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
    output full, empty, almost_full, almost_empty, level
  );

endinterface

// File: rtl/fifo_sync_cfg_ptr_ctrl.sv
// Pointer, occupancy and accept control for fifo_sync_cfg.
// Accept decisions are combinational; pointers and level update on the next edge.
// Writes are refused when full unless a read is accepted in the same cycle.
module fifo_ptr_ctrl
  import fifo_cfg_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int AF_THRESH = DEPTH - 1,
  parameter  int AE_THRESH = 1,
  localparam int LVL_W     = calc_lvl_w(DEPTH),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             wr_ok,
  output logic             rd_ok,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [LVL_W-1:0] level_next;

  // Status flags are straight decodes of the level register.
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // A simultaneous read frees a slot, so a write while full still lands.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Occupancy moves by at most one per cycle.
  always_comb begin
    level_next = level;
    if (wr_ok && !rd_ok) begin
      level_next = level + LVL_W'(1);
    end else if (!wr_ok && rd_ok) begin
      level_next = level - LVL_W'(1);
    end
  end

  // Pointer and level state; flush wins over any request in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_W'(1);
      level <= level_next;
    end
  end

endmodule

// File: rtl/fifo_sync_cfg.sv
// Parametrised single-clock FIFO with registered or fall-through read mode.
// Registered mode: data 1 cycle after rd_en; fall-through: head visible while non-empty.
// Overflowing writes are dropped and flagged; write-while-full is allowed with a same-cycle read.
module fifo_sync_cfg
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int FWFT      = MODE_REG,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input logic           clk,
  input logic           rst,
  fifo_sync_cfg_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  if (!cfg_legal(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_cfg
    $fatal(1, "fifo_sync_cfg: illegal DEPTH/AE_THRESH/AF_THRESH combination");
  end

  logic                     wr_ok;
  logic                     rd_ok;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic signed [DATA_W-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush        (bus.flush),
    .wr_en        (bus.wr_en),
    .rd_en        (bus.rd_en),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .level        (bus.level),
    .full         (bus.full),
    .empty        (bus.empty),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty)
  );

  // Storage is left unreset; pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) mem[wr_ptr] <= bus.data_in;
  end

  // Request outcome flags, reported one cycle after the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bus.flush) begin
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.wr_ack    <= wr_ok;
      bus.overflow  <= bus.wr_en && !wr_ok;
      bus.underflow <= bus.rd_en && !rd_ok;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head of queue is shown directly; zero when nothing is stored.
    assign bus.data_out = bus.empty ? '0 : mem[rd_ptr];
    assign bus.rd_valid = !bus.empty;
  end else begin : g_reg
    logic signed [DATA_W-1:0] data_q;
    logic                     valid_q;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (bus.flush) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) data_q <= mem[rd_ptr];
      end
    end

    assign bus.data_out = data_q;
    assign bus.rd_valid = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Directed bench for fifo_sync_cfg: registered and fall-through modes at depth 8,
// plus a depth-6 registered instance for wraparound and mid-run async reset.
module tb_fifo_sync_cfg;
  import fifo_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fifo_sync_cfg_if #(.DATA_W(32), .DEPTH(8)) b0 ();
  fifo_sync_cfg_if #(.DATA_W(32), .DEPTH(8)) b1 ();
  fifo_sync_cfg_if #(.DATA_W(32), .DEPTH(6)) b2 ();

  fifo_sync_cfg #(.DATA_W(32), .DEPTH(8), .FWFT(MODE_REG), .AF_THRESH(6), .AE_THRESH(2))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  fifo_sync_cfg #(.DATA_W(32), .DEPTH(8), .FWFT(MODE_FWFT), .AF_THRESH(6), .AE_THRESH(2))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fifo_sync_cfg #(.DATA_W(32), .DEPTH(6), .FWFT(MODE_REG), .AF_THRESH(5), .AE_THRESH(1))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    b0.flush = 0; b0.wr_en = 0; b0.rd_en = 0; b0.data_in = 0;
    b1.flush = 0; b1.wr_en = 0; b1.rd_en = 0; b1.data_in = 0;
    b2.flush = 0; b2.wr_en = 0; b2.rd_en = 0; b2.data_in = 0;
  endtask

  task automatic test_reset;
    idle_all();
    rst = 1;
    #12;
    tests++; if (b0.level !== 4'd0) begin fails++; $display("FAIL rst_level: got %0d want 0", b0.level); end
    tests++; if (b0.empty !== 1'b1 || b0.full !== 1'b0) begin fails++; $display("FAIL rst_flags: empty %b full %b want 1 0", b0.empty, b0.full); end
    tests++; if (b0.rd_valid !== 1'b0 || b0.data_out !== 32'sd0) begin fails++; $display("FAIL rst_dout: valid %b data %0d want 0 0", b0.rd_valid, b0.data_out); end
    tests++; if ({b0.wr_ack, b0.overflow, b0.underflow} !== 3'b000) begin fails++; $display("FAIL rst_status: got %b want 000", {b0.wr_ack, b0.overflow, b0.underflow}); end
    tests++; if (b1.rd_valid !== 1'b0 || b1.data_out !== 32'sd0) begin fails++; $display("FAIL rst_fwft: valid %b data %0d want 0 0", b1.rd_valid, b1.data_out); end
    tests++; if (b0.almost_empty !== 1'b1 || b0.almost_full !== 1'b0) begin fails++; $display("FAIL rst_almost: ae %b af %b want 1 0", b0.almost_empty, b0.almost_full); end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_fill_overflow_drain;
    for (int i = 1; i <= 8; i++) begin
      b0.wr_en = 1; b0.data_in = i;
      tick();
      tests++; if (b0.level !== 4'(i)) begin fails++; $display("FAIL t1_level%0d: got %0d want %0d", i, b0.level, i); end
      tests++; if (b0.almost_empty !== (i <= 2)) begin fails++; $display("FAIL t1_ae%0d: got %b want %b", i, b0.almost_empty, (i <= 2)); end
      tests++; if (b0.almost_full !== (i >= 6)) begin fails++; $display("FAIL t1_af%0d: got %b want %b", i, b0.almost_full, (i >= 6)); end
      tests++; if (b0.full !== (i == 8)) begin fails++; $display("FAIL t1_full%0d: got %b want %b", i, b0.full, (i == 8)); end
      tests++; if (b0.wr_ack !== 1'b1) begin fails++; $display("FAIL t1_ack%0d: got %b want 1", i, b0.wr_ack); end
    end
    b0.data_in = 9;
    tick();
    b0.wr_en = 0;
    tests++; if (b0.overflow !== 1'b1 || b0.wr_ack !== 1'b0) begin fails++; $display("FAIL t1_ovf: ovf %b ack %b want 1 0", b0.overflow, b0.wr_ack); end
    tests++; if (b0.level !== 4'd8) begin fails++; $display("FAIL t1_ovf_level: got %0d want 8", b0.level); end
    for (int i = 1; i <= 8; i++) begin
      b0.rd_en = 1;
      tick();
      b0.rd_en = 0;
      tests++; if (b0.rd_valid !== 1'b1 || b0.data_out !== i) begin fails++; $display("FAIL t1_rd%0d: valid %b data %0d want 1 %0d", i, b0.rd_valid, b0.data_out, i); end
      tick();
      tests++; if (b0.rd_valid !== 1'b0 || b0.data_out !== i) begin fails++; $display("FAIL t1_hold%0d: valid %b data %0d want 0 %0d", i, b0.rd_valid, b0.data_out, i); end
    end
    tests++; if (b0.empty !== 1'b1) begin fails++; $display("FAIL t1_empty: got %b want 1", b0.empty); end
  endtask

  task automatic test_write_while_full;
    for (int i = 1; i <= 8; i++) begin
      b0.wr_en = 1; b0.data_in = i;
      tick();
    end
    b0.data_in = 100; b0.rd_en = 1;
    tick();
    b0.wr_en = 0;
    tests++; if (b0.wr_ack !== 1'b1 || b0.overflow !== 1'b0) begin fails++; $display("FAIL t2_ack: ack %b ovf %b want 1 0", b0.wr_ack, b0.overflow); end
    tests++; if (b0.level !== 4'd8) begin fails++; $display("FAIL t2_level: got %0d want 8", b0.level); end
    tests++; if (b0.data_out !== 32'sd1 || b0.rd_valid !== 1'b1) begin fails++; $display("FAIL t2_dout: data %0d valid %b want 1 1", b0.data_out, b0.rd_valid); end
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++; if (b0.data_out !== ((k < 7) ? k + 2 : 100)) begin fails++; $display("FAIL t2_drain%0d: got %0d want %0d", k, b0.data_out, (k < 7) ? k + 2 : 100); end
    end
    b0.rd_en = 0;
    tick();
    tests++; if (b0.empty !== 1'b1 || b0.underflow !== 1'b0) begin fails++; $display("FAIL t2_end: empty %b unf %b want 1 0", b0.empty, b0.underflow); end
  endtask

  task automatic test_empty_rw;
    b0.wr_en = 1; b0.rd_en = 1; b0.data_in = -5;
    tick();
    b0.wr_en = 0;
    tests++; if (b0.underflow !== 1'b1 || b0.level !== 4'd1) begin fails++; $display("FAIL t3_unf: unf %b level %0d want 1 1", b0.underflow, b0.level); end
    tests++; if (b0.rd_valid !== 1'b0) begin fails++; $display("FAIL t3_nobypass: valid %b want 0", b0.rd_valid); end
    tick();
    b0.rd_en = 0;
    tests++; if (b0.data_out !== -32'sd5 || b0.rd_valid !== 1'b1) begin fails++; $display("FAIL t3_sign: data %0d valid %b want -5 1", b0.data_out, b0.rd_valid); end
    tests++; if (b0.underflow !== 1'b0 || b0.empty !== 1'b1) begin fails++; $display("FAIL t3_end: unf %b empty %b want 0 1", b0.underflow, b0.empty); end
  endtask

  task automatic test_fwft;
    b1.wr_en = 1; b1.data_in = 32'hA;
    tick();
    tests++; if (b1.data_out !== 32'sh0A || b1.rd_valid !== 1'b1) begin fails++; $display("FAIL t4_first: data %0h valid %b want a 1", b1.data_out, b1.rd_valid); end
    b1.data_in = 32'hB;
    tick();
    b1.wr_en = 0;
    tests++; if (b1.data_out !== 32'sh0A) begin fails++; $display("FAIL t4_head: got %0h want a", b1.data_out); end
    b1.rd_en = 1;
    tick();
    tests++; if (b1.data_out !== 32'sh0B || b1.rd_valid !== 1'b1) begin fails++; $display("FAIL t4_pop1: data %0h valid %b want b 1", b1.data_out, b1.rd_valid); end
    tick();
    b1.rd_en = 0;
    tests++; if (b1.data_out !== 32'sd0 || b1.rd_valid !== 1'b0) begin fails++; $display("FAIL t4_pop2: data %0h valid %b want 0 0", b1.data_out, b1.rd_valid); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) begin
      b0.wr_en = 1; b0.data_in = 10 + i;
      tick();
    end
    tests++; if (b0.level !== 4'd5) begin fails++; $display("FAIL t5_pre: got %0d want 5", b0.level); end
    b0.flush = 1; b0.wr_en = 1; b0.rd_en = 1; b0.data_in = 77;
    tick();
    b0.flush = 0; b0.wr_en = 0; b0.rd_en = 0;
    tests++; if (b0.level !== 4'd0 || b0.empty !== 1'b1) begin fails++; $display("FAIL t5_level: level %0d empty %b want 0 1", b0.level, b0.empty); end
    tests++; if ({b0.wr_ack, b0.overflow, b0.underflow, b0.rd_valid} !== 4'b0000) begin fails++; $display("FAIL t5_flags: got %b want 0000", {b0.wr_ack, b0.overflow, b0.underflow, b0.rd_valid}); end
    tests++; if (b0.data_out !== 32'sd0) begin fails++; $display("FAIL t5_dout: got %0d want 0", b0.data_out); end
    b0.wr_en = 1; b0.data_in = 55;
    tick();
    b0.wr_en = 0; b0.rd_en = 1;
    tick();
    b0.rd_en = 0;
    tests++; if (b0.data_out !== 32'sd55 || b0.rd_valid !== 1'b1) begin fails++; $display("FAIL t5_new: data %0d valid %b want 55 1", b0.data_out, b0.rd_valid); end
  endtask

  task automatic test_wrap_depth6;
    int q[$];
    int val;
    int exp;
    bit do_wr;
    bit do_rd;
    val = 1;
    for (int i = 0; i < 4; i++) begin
      b2.wr_en = 1; b2.data_in = val; q.push_back(val); val++;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      do_wr = ((i % 4) != 3);
      do_rd = ((i % 4) != 1);
      exp = 0;
      b2.wr_en = do_wr; b2.rd_en = do_rd; b2.data_in = val;
      if (do_rd) exp = q.pop_front();
      if (do_wr) begin q.push_back(val); val++; end
      tick();
      tests++; if (b2.level !== q.size()) begin fails++; $display("FAIL t6_level%0d: got %0d want %0d", i, b2.level, q.size()); end
      tests++; if (b2.full !== 1'b0 || b2.empty !== 1'b0) begin fails++; $display("FAIL t6_flags%0d: full %b empty %b want 0 0", i, b2.full, b2.empty); end
      if (do_rd) begin
        tests++; if (b2.rd_valid !== 1'b1 || b2.data_out !== exp) begin fails++; $display("FAIL t6_data%0d: valid %b data %0d want 1 %0d", i, b2.rd_valid, b2.data_out, exp); end
      end else begin
        tests++; if (b2.rd_valid !== 1'b0) begin fails++; $display("FAIL t6_idle%0d: valid %b want 0", i, b2.rd_valid); end
      end
    end
    b2.wr_en = 0; b2.rd_en = 0;
    #2 rst = 1;
    #1;
    tests++; if (b2.level !== 3'd0 || b2.empty !== 1'b1) begin fails++; $display("FAIL t6_arst: level %0d empty %b want 0 1", b2.level, b2.empty); end
    tests++; if (b2.rd_valid !== 1'b0 || b2.data_out !== 32'sd0) begin fails++; $display("FAIL t6_arst_dout: valid %b data %0d want 0 0", b2.rd_valid, b2.data_out); end
    #1 rst = 0;
    b2.rd_en = 1;
    tick();
    b2.rd_en = 0;
    tests++; if (b2.underflow !== 1'b1 || b2.rd_valid !== 1'b0 || b2.data_out !== 32'sd0) begin fails++; $display("FAIL t6_post: unf %b valid %b data %0d want 1 0 0", b2.underflow, b2.rd_valid, b2.data_out); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow_drain();
    test_write_while_full();
    test_empty_rw();
    test_fwft();
    test_flush();
    test_wrap_depth6();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_sync_cfg.md
Name: fifo_sync_cfg

Overview:
- Parametrised synchronous single-clock FIFO; successor to the team's fixed 32x8 FIFO.
- Used between BiLSTM pipeline stages, e.g. gate-result buffering and the hidden-state feedback queue.
- Adds a selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy level output, synchronous flush, and write-while-full when a read happens in the same cycle.

Parameters:
- DATA_W, 32, data word width in bits; data is signed.
- DEPTH, 8, number of entries; any value >= 2, not required to be a power of two.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH.
- LVL_W, $clog2(DEPTH+1), width of the level output; derived, not for override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  DATA_W  signed write data.
- rd_en  in  1  read/pop request.
- data_out  out  DATA_W  signed read data.
- rd_valid  out  1  data_out holds a newly read word.
- wr_ack  out  1  previous-cycle write was accepted.
- overflow  out  1  previous-cycle write was rejected.
- underflow  out  1  previous-cycle read was rejected.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  LVL_W  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and level are cleared to 0.
  - data_out, rd_valid, wr_ack, overflow and underflow are 0.
  - Memory contents are not reset.
- Flags: full, empty, almost_full, almost_empty and level are combinational decodes of the level register.
- Pointers: wrap from DEPTH-1 to 0 using an explicit compare, never natural overflow.
- Read accept: rd_ok = rd_en && !empty.
- Write accept: wr_ok = wr_en && (!full || rd_ok). A write while full with a read in the same cycle is accepted.
- Empty with wr_en=1 and rd_en=1: the write is accepted and the read is rejected (underflow). There is no bypass of data_in to data_out.
- level_next = level + wr_ok - rd_ok.
- wr_ack / overflow: registered, one cycle after the request. wr_ack = wr_ok; overflow = wr_en && !wr_ok.
- underflow: registered, equals rd_en && !rd_ok.
- FWFT=0 (registered read):
  - On rd_ok, data_out <= mem[rd_ptr] and rd_valid pulses high the next cycle (1-cycle latency).
  - data_out holds its value when there is no read.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally whenever !empty; otherwise data_out = 0.
  - rd_valid = !empty.
  - rd_en pops the head and the next word is visible in the following cycle.
- Flush (synchronous):
  - Clears both pointers and level.
  - Forces wr_ack, overflow, underflow and rd_valid to 0 and data_out to 0.
  - Has priority over wr_en/rd_en in the same cycle; that cycle's requests are discarded with no flags raised.
- rst asserted mid-transfer aborts immediately. After release the FIFO reads empty and no stale data is presented.
- Elaboration checks: DEPTH >= 2, 0 <= AE_THRESH < AF_THRESH <= DEPTH. A violation is a fatal elaboration error.

Decomposition:
- Package fifo_cfg_pkg:
  - read-mode constants MODE_REG = 0, MODE_FWFT = 1;
  - a function computing LVL_W;
  - the threshold legality check.
- One sub-module, fifo_ptr_ctrl: owns pointers, level, accept logic and flags.
- Top level: memory array, read datapath (mode-dependent) and status registers.

Test Plan (DEPTH=8, AF_THRESH=6, AE_THRESH=2, DATA_W=32 unless stated):
1. Reset, then 8 writes of values 1..8, then wr_en with data 9 (FWFT=0):
   - After the 2nd write level=2 and almost_empty=1.
   - After the 6th write almost_full=1; after the 8th, full=1.
   - The 9th write gives overflow=1 on the next cycle with level still 8.
   - 8 reads return 1..8, each with a rd_valid pulse one cycle after rd_en.
2. Full FIFO, wr_en=1 (data 100) and rd_en=1 in the same cycle:
   - wr_ack=1, overflow=0, level stays 8, data_out=1.
   - 100 is read last.
3. Empty FIFO, wr_en=1 (data -5) and rd_en=1:
   - underflow=1 and level=1.
   - The next read returns -5; sign is preserved.
4. FWFT=1, write 0xA then 0xB:
   - data_out=0xA with rd_valid=1 the cycle after the first write, with no rd_en.
   - Pulse rd_en: data_out=0xB the next cycle.
   - Pop again: rd_valid=0 and data_out=0.
5. Level 5, flush=1 with wr_en=1 and rd_en=1:
   - The next cycle shows level=0, empty=1, and wr_ack, overflow, underflow and rd_valid all 0.
   - A subsequent write then read returns the new word.
6. DEPTH=6 (non power of two):
   - Run 20 write/read cycles interleaved so level stays at 3-5, with pointers wrapping 5->0 at least three times.
   - Data order is preserved and there are no spurious full/empty flags.
   - An async rst in the middle of this sequence clears level to 0 without waiting for a clock edge.
